// File: rtl/io_ctrl_sequencer_pkg.sv
// io_ctrl_sequencer_pkg: opcodes, state encoding, strobe vector and counter width for the sequencer (STEP_HOLD exists only with SINGLE_STEP_EN)
package io_ctrl_sequencer_pkg;
  localparam logic [4:0] OP_IN = 5'd22;
  localparam logic [4:0] OP_OUT = 5'd23;
  localparam logic [4:0] OP_MFHI = 5'd24;
  localparam logic [4:0] OP_MFLO = 5'd25;
  localparam logic [4:0] OP_NOP = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;
  localparam int CNT_W = 4;
  typedef enum logic [2:0] {
    RESET,
    FETCH0,
    FETCH1,
    FETCH2,
    EXEC,
`ifdef SINGLE_STEP_EN
    STEP_HOLD,
`endif
    HALTED
  } state_e;
  typedef struct packed {
    logic pc_out;
    logic inc_pc;
    logic mar_in;
    logic z_in;
    logic zlo_out;
    logic pc_in;
    logic mdr_in;
    logic mem_read;
    logic mem_en;
    logic mdr_out;
    logic ir_in;
    logic gra;
    logic rin;
    logic rout;
    logic outport_in;
    logic inport_out;
    logic hi_out;
    logic lo_out;
    logic in_ack;
    logic illegal_op;
    logic running;
  } strobe_t;
  function automatic logic op_legal(input logic [4:0] op);
    return op inside {OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_NOP, OP_HALT};
  endfunction
endpackage

// File: rtl/io_ctrl_sequencer_if.sv
// io_ctrl_sequencer_if: opcode/ready inputs and control strobes between sequencer and datapath; step exists with SINGLE_STEP_EN
interface io_ctrl_sequencer_if;
  logic [4:0] ir_opcode;
  logic inport_data_ready;
`ifdef SINGLE_STEP_EN
  logic step;
`endif
  logic PCout, IncPC, MARin, Zin;
  logic Zlo_out, PCin, MDRin, Mem_Read, Mem_enable512x32;
  logic MDRout, IRin;
  logic Gra, Rin, Rout, outport_in, Inport_out, HIout, LOout;
  logic in_ack, illegal_op, running;
  modport master(
`ifdef SINGLE_STEP_EN
    input step,
`endif
    input ir_opcode, inport_data_ready,
    output PCout, IncPC, MARin, Zin, Zlo_out, PCin, MDRin, Mem_Read, Mem_enable512x32,
    output MDRout, IRin, Gra, Rin, Rout, outport_in, Inport_out, HIout, LOout,
    output in_ack, illegal_op, running
  );
  modport slave(
`ifdef SINGLE_STEP_EN
    output step,
`endif
    output ir_opcode, inport_data_ready,
    input PCout, IncPC, MARin, Zin, Zlo_out, PCin, MDRin, Mem_Read, Mem_enable512x32,
    input MDRout, IRin, Gra, Rin, Rout, outport_in, Inport_out, HIout, LOout,
    input in_ack, illegal_op, running
  );
endinterface

// File: rtl/io_ctrl_sequencer_ctrl_strobe_decode.sv
// io_ctrl_sequencer_ctrl_strobe_decode: combinational state + opcode + ready -> control strobe vector
module io_ctrl_sequencer_ctrl_strobe_decode
  import io_ctrl_sequencer_pkg::*;
(
  input  state_e     st,
  input  logic       first,
  input  logic [4:0] op,
  input  logic       rdy,
  output strobe_t    s
);
  logic ex, in_go, mv;
  assign ex = st == EXEC;
  assign in_go = ex && op == OP_IN && rdy;
  assign mv = ex && (op == OP_MFHI || op == OP_MFLO);
  // one-hot per step; EXEC strobes gated by opcode, in waits silently until ready
  always_comb begin
    s = '0;
    s.running = st != RESET && st != HALTED;
    s.pc_out = st == FETCH0;
    s.inc_pc = st == FETCH0;
    s.mar_in = st == FETCH0;
    s.z_in = st == FETCH0;
    s.zlo_out = st == FETCH1 && first;
    s.pc_in = st == FETCH1 && first;
    s.mdr_in = st == FETCH1;
    s.mem_read = st == FETCH1;
    s.mem_en = st == FETCH1;
    s.mdr_out = st == FETCH2;
    s.ir_in = st == FETCH2;
    s.gra = in_go || mv || (ex && op == OP_OUT);
    s.rin = in_go || mv;
    s.rout = ex && op == OP_OUT;
    s.outport_in = ex && op == OP_OUT;
    s.inport_out = in_go;
    s.hi_out = ex && op == OP_MFHI;
    s.lo_out = ex && op == OP_MFLO;
    s.in_ack = in_go;
    s.illegal_op = ex && !op_legal(op);
  end
endmodule

// File: rtl/io_ctrl_sequencer.sv
// io_ctrl_sequencer: FETCH0..EXEC control-step sequencer with memory-latency hold; SINGLE_STEP_EN adds step input and STEP_HOLD
module io_ctrl_sequencer
  import io_ctrl_sequencer_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input logic Clock,
  input logic clear,
  io_ctrl_sequencer_if.master bus
);
  localparam int LAT_I = MEM_LATENCY < 1 ? 1 : (MEM_LATENCY > 15 ? 15 : MEM_LATENCY);
  localparam logic [CNT_W-1:0] LAT = CNT_W'(LAT_I);
`ifdef SINGLE_STEP_EN
  localparam state_e AFTER_EXEC = STEP_HOLD;
`else
  localparam state_e AFTER_EXEC = FETCH0;
`endif
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  strobe_t s;
  // next state; FETCH1 counts down the memory latency loaded on FETCH0 exit
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    unique case (state_q)
      RESET: state_d = FETCH0;
      FETCH0: begin
        state_d = FETCH1;
        cnt_d = LAT;
      end
      FETCH1: begin
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == CNT_W'(1) ? FETCH2 : FETCH1;
      end
      FETCH2: state_d = EXEC;
      EXEC: state_d = bus.ir_opcode == OP_HALT ? HALTED :
                      (bus.ir_opcode == OP_IN && !bus.inport_data_ready) ? EXEC : AFTER_EXEC;
`ifdef SINGLE_STEP_EN
      STEP_HOLD: state_d = bus.step ? FETCH0 : STEP_HOLD;
`endif
      HALTED: state_d = HALTED;
      default: state_d = RESET;
    endcase
  end
  // state and latency counter; clear overrides everything
  always_ff @(posedge Clock) begin
    if (clear) begin
      state_q <= RESET;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  io_ctrl_sequencer_ctrl_strobe_decode u_dec (
    .st(state_q),
    .first(cnt_q == LAT),
    .op(bus.ir_opcode),
    .rdy(bus.inport_data_ready),
    .s(s)
  );
  assign {bus.PCout, bus.IncPC, bus.MARin, bus.Zin, bus.Zlo_out, bus.PCin, bus.MDRin,
          bus.Mem_Read, bus.Mem_enable512x32, bus.MDRout, bus.IRin, bus.Gra, bus.Rin,
          bus.Rout, bus.outport_in, bus.Inport_out, bus.HIout, bus.LOout, bus.in_ack,
          bus.illegal_op, bus.running} = s;
endmodule

// File: tb/tb_io_ctrl_sequencer.sv
// tb_io_ctrl_sequencer: directed checks of fetch/exec strobes, in-wait, latency 3, halt and clear (SINGLE_STEP_EN adds step holds)
module tb_io_ctrl_sequencer;
  import io_ctrl_sequencer_pkg::*;
  localparam logic [20:0] E_RST = 21'b0000_00000_00_0000000_000;
  localparam logic [20:0] E_RUN = 21'b0000_00000_00_0000000_001;
  localparam logic [20:0] E_F0 = 21'b1111_00000_00_0000000_001;
  localparam logic [20:0] E_F1A = 21'b0000_11111_00_0000000_001;
  localparam logic [20:0] E_F1B = 21'b0000_00111_00_0000000_001;
  localparam logic [20:0] E_F2 = 21'b0000_00000_11_0000000_001;
  localparam logic [20:0] E_OUT = 21'b0000_00000_00_1011000_001;
  localparam logic [20:0] E_IN = 21'b0000_00000_00_1100100_101;
  localparam logic [20:0] E_HI = 21'b0000_00000_00_1100010_001;
  localparam logic [20:0] E_LO = 21'b0000_00000_00_1100001_001;
  localparam logic [20:0] E_ILL = 21'b0000_00000_00_0000000_011;
  logic Clock = 1'b0;
  logic clear = 1'b1;
  int errs = 0;
  int checks = 0;
  logic [20:0] va, vb;
  io_ctrl_sequencer_if if_a();
  io_ctrl_sequencer_if if_b();
  io_ctrl_sequencer #(.MEM_LATENCY(1)) dut_a (.Clock(Clock), .clear(clear), .bus(if_a.master));
  io_ctrl_sequencer #(.MEM_LATENCY(3)) dut_b (.Clock(Clock), .clear(clear), .bus(if_b.master));
  always #5 Clock = ~Clock;
  assign va = {if_a.PCout, if_a.IncPC, if_a.MARin, if_a.Zin, if_a.Zlo_out, if_a.PCin, if_a.MDRin,
               if_a.Mem_Read, if_a.Mem_enable512x32, if_a.MDRout, if_a.IRin, if_a.Gra, if_a.Rin,
               if_a.Rout, if_a.outport_in, if_a.Inport_out, if_a.HIout, if_a.LOout, if_a.in_ack,
               if_a.illegal_op, if_a.running};
  assign vb = {if_b.PCout, if_b.IncPC, if_b.MARin, if_b.Zin, if_b.Zlo_out, if_b.PCin, if_b.MDRin,
               if_b.Mem_Read, if_b.Mem_enable512x32, if_b.MDRout, if_b.IRin, if_b.Gra, if_b.Rin,
               if_b.Rout, if_b.outport_in, if_b.Inport_out, if_b.HIout, if_b.LOout, if_b.in_ack,
               if_b.illegal_op, if_b.running};
  task automatic chk(input string tag, input logic [20:0] obs, input logic [20:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge Clock);
    #1;
  endtask
  task automatic cyc(input string tag, input logic [20:0] e);
    tick();
    chk(tag, va, e);
  endtask
  task automatic drive(input logic [4:0] op, input logic rdy);
    if_a.ir_opcode = op;
    if_b.ir_opcode = op;
    if_a.inport_data_ready = rdy;
    if_b.inport_data_ready = rdy;
  endtask
  task automatic set_step(input logic v);
`ifdef SINGLE_STEP_EN
    if_a.step = v;
    if_b.step = v;
`else
    if (v) $display("note: step ignored without single-step build");
`endif
  endtask
  task automatic to_fetch0(input string tag);
`ifdef SINGLE_STEP_EN
    cyc({tag, "_hold"}, E_RUN);
    cyc({tag, "_hold2"}, E_RUN);
    set_step(1'b1);
    cyc({tag, "_f0"}, E_F0);
    set_step(1'b0);
`else
    cyc({tag, "_f0"}, E_F0);
`endif
  endtask
  task automatic instr(input string tag, input logic [4:0] op, input logic [20:0] ex);
    drive(op, 1'b0);
    cyc({tag, "_f1"}, E_F1A);
    cyc({tag, "_f2"}, E_F2);
    cyc({tag, "_exec"}, ex);
    to_fetch0(tag);
  endtask
  initial begin
    drive(OP_OUT, 1'b0);
`ifdef SINGLE_STEP_EN
    set_step(1'b0);
`endif
    tick();
    tick();
    chk("reset_a", va, E_RST);
    chk("reset_b", vb, E_RST);
    clear = 1'b0;
    tick();
    chk("out_f0", va, E_F0);
    chk("b_f0", vb, E_F0);
    tick();
    chk("out_f1", va, E_F1A);
    chk("b_f1_1", vb, E_F1A);
    tick();
    chk("out_f2", va, E_F2);
    chk("b_f1_2", vb, E_F1B);
    tick();
    chk("out_exec", va, E_OUT);
    chk("b_f1_3", vb, E_F1B);
`ifdef SINGLE_STEP_EN
    tick();
    chk("out_hold", va, E_RUN);
    chk("b_f2", vb, E_F2);
    set_step(1'b1);
    tick();
    chk("out_next_f0", va, E_F0);
    chk("b_exec", vb, E_OUT);
    set_step(1'b0);
    cyc("f1_after_out", E_F1A);
`else
    tick();
    chk("out_next_f0", va, E_F0);
    chk("b_f2", vb, E_F2);
    tick();
    chk("f1_after_out", va, E_F1A);
    chk("b_exec", vb, E_OUT);
`endif
    drive(OP_IN, 1'b0);
    cyc("in_f2", E_F2);
    cyc("in_wait1", E_RUN);
    cyc("in_wait2", E_RUN);
    cyc("in_wait3", E_RUN);
    tick();
    drive(OP_IN, 1'b1);
    #1;
    chk("in_exec", va, E_IN);
    to_fetch0("in");
    instr("mfhi", OP_MFHI, E_HI);
    instr("mflo", OP_MFLO, E_LO);
    instr("nop", OP_NOP, E_RUN);
    instr("illegal", 5'd31, E_ILL);
    drive(OP_HALT, 1'b0);
    cyc("halt_f1", E_F1A);
    cyc("halt_f2", E_F2);
    cyc("halt_exec", E_RUN);
    for (int i = 0; i < 20; i++) cyc("halted", E_RST);
    clear = 1'b1;
    cyc("clr_reset", E_RST);
    clear = 1'b0;
    cyc("clr_f0", E_F0);
    cyc("clr_f1", E_F1A);
    clear = 1'b1;
    cyc("midfetch_reset", E_RST);
    clear = 1'b0;
    cyc("midfetch_f0", E_F0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
